// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Instruction encoding used for pipeline bubbles.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  // Default PC after reset.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // S_REQ : request outstanding (or being issued) at AddrReg
  // S_HOLD: downstream stalled, fetched instruction parked in InstBuf
  // S_DROP: redirect arrived while a fetch was in flight; wait for ack and discard it
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Force word alignment of an address.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Holds the PC, issues req/ack fetches, presents instruction and PC+4 to IF/ID.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   DataHazard, ControlHazard        stall / redirect from downstream
//   BranchTarget                     redirect address (low 2 bits ignored)
//   IMemReq, IMemAddr                fetch request and address to instruction memory
//   IMemAck, IMemRData               fetch completion and returned instruction
//   IFInstruction, IFPc4, FetchBusy  presented instruction (0 = bubble), PC+4, bubble flag
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DataHazard,
  input  logic        ControlHazard,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] IFInstruction,
  output logic [31:0] IFPc4,
  output logic        FetchBusy
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] inst_buf_q, inst_buf_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            valid;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign target   = align_word(BranchTarget);

  // Presented instruction / request; rst_n gating keeps outputs quiet during reset.
  always_comb begin
    valid         = 1'b0;
    IFInstruction = NOP_INSTR;
    IMemReq       = 1'b0;
    if (rst_n) begin
      IMemReq = (state_q != S_HOLD);
      if (state_q == S_REQ && IMemAck) begin
        valid         = 1'b1;
        IFInstruction = IMemRData;
      end else if (state_q == S_HOLD) begin
        valid         = 1'b1;
        IFInstruction = inst_buf_q;
      end
    end
  end

  assign IMemAddr  = addr_q;
  assign IFPc4     = valid ? pc_plus4 : '0;
  assign FetchBusy = ~valid;

  // Next-state / next-PC logic; ControlHazard takes priority over DataHazard.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    inst_buf_d = inst_buf_q;
    unique case (state_q)
      S_REQ: begin
        if (ControlHazard) begin
          pc_d = target;
          if (IMemAck) begin
            addr_d = target;
          end else begin
            // Request must complete at the old address before redirecting.
            state_d = S_DROP;
          end
        end else if (IMemAck) begin
          if (DataHazard) begin
            inst_buf_d = IMemRData;
            state_d    = S_HOLD;
          end else begin
            pc_d   = pc_plus4;
            addr_d = pc_plus4;
          end
        end
      end
      S_HOLD: begin
        if (ControlHazard) begin
          pc_d    = target;
          addr_d  = target;
          state_d = S_REQ;
        end else if (!DataHazard) begin
          pc_d    = pc_plus4;
          addr_d  = pc_plus4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (ControlHazard) begin
          pc_d = target;
        end
        if (IMemAck) begin
          // Stale data discarded; next fetch goes to the newest redirect PC.
          addr_d  = pc_d;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inst_buf_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inst_buf_q <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: expected instructions are queued when a
// valid presentation is anticipated and popped when the DUT presents one.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        DataHazard;
  logic        ControlHazard;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] IFInstruction;
  logic [31:0] IFPc4;
  logic        FetchBusy;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb_q[$];

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .DataHazard    (DataHazard),
    .ControlHazard (ControlHazard),
    .BranchTarget  (BranchTarget),
    .IMemReq       (IMemReq),
    .IMemAddr      (IMemAddr),
    .IMemAck       (IMemAck),
    .IMemRData     (IMemRData),
    .IFInstruction (IFInstruction),
    .IFPc4         (IFPc4),
    .FetchBusy     (FetchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, check combinational outputs, advance.
  // exp_valid means IFInstruction = 0x1000+addr and IFPc4 = addr+4.
  task automatic step(input string tag, input logic ack, input logic dh, input logic ch,
                      input logic [31:0] tgt, input logic exp_req,
                      input logic [31:0] exp_addr, input logic exp_valid);
    exp_t e;
    IMemAck       = ack;
    DataHazard    = dh;
    ControlHazard = ch;
    BranchTarget  = tgt;
    IMemRData     = ack ? (32'h0000_1000 + IMemAddr) : 32'hDEAD_BEEF;
    if (exp_valid) begin
      e.inst = 32'h0000_1000 + exp_addr;
      e.pc4  = exp_addr + 32'd4;
      sb_q.push_back(e);
    end
    #1;
    chk({tag, ".req"},  32'(IMemReq), 32'(exp_req));
    chk({tag, ".addr"}, IMemAddr, exp_addr);
    chk({tag, ".busy"}, 32'(FetchBusy), 32'(!exp_valid));
    if (!exp_valid) begin
      chk({tag, ".bubble_inst"}, IFInstruction, 32'h0);
      chk({tag, ".bubble_pc4"},  IFPc4, 32'h0);
    end
    if (!FetchBusy) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".unexpected_valid"}, 32'(FetchBusy), 32'h1);
      end else begin
        e = sb_q.pop_front();
        chk({tag, ".inst"}, IFInstruction, e.inst);
        chk({tag, ".pc4"},  IFPc4, e.pc4);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req"},  32'(IMemReq), 32'h0);
    chk({tag, ".addr"}, IMemAddr, 32'h0);
    chk({tag, ".inst"}, IFInstruction, 32'h0);
    chk({tag, ".pc4"},  IFPc4, 32'h0);
    chk({tag, ".busy"}, 32'(FetchBusy), 32'h1);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    DataHazard    = 1'b0;
    ControlHazard = 1'b0;
    BranchTarget  = 32'h0;
    IMemAck       = 1'b1;       // ack during reset must be ignored
    IMemRData     = 32'h1234_5678;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait memory
    step("zw0", 1, 0, 0, 32'h0, 1, 32'h0000_0000, 1);
    step("zw1", 1, 0, 0, 32'h0, 1, 32'h0000_0004, 1);
    // DataHazard for 3 cycles on ack of PC=8, then release
    step("dh0", 1, 1, 0, 32'h0, 1, 32'h0000_0008, 1);
    step("dh1", 0, 1, 0, 32'h0, 0, 32'h0000_0008, 1);
    step("dh2", 0, 1, 0, 32'h0, 0, 32'h0000_0008, 1);
    step("dh3", 0, 0, 0, 32'h0, 0, 32'h0000_0008, 1);
    // One wait cycle per fetch: bubble, address stable
    step("wt0", 0, 0, 0, 32'h0, 1, 32'h0000_000C, 0);
    step("wt1", 1, 0, 0, 32'h0, 1, 32'h0000_000C, 1);
    // Redirect to 0x43 while fetch of 0x10 is in flight
    step("cd0", 0, 0, 1, 32'h43, 1, 32'h0000_0010, 0);
    step("cd1", 0, 0, 0, 32'h0,  1, 32'h0000_0010, 0);
    step("cd2", 1, 0, 0, 32'h0,  1, 32'h0000_0010, 0);
    step("cd3", 1, 0, 0, 32'h0,  1, 32'h0000_0040, 1);
    // Redirect and stall in the same cycle while holding: redirect wins
    step("cs0", 1, 1, 0, 32'h0,  1, 32'h0000_0044, 1);
    step("cs1", 0, 1, 1, 32'h80, 0, 32'h0000_0044, 1);
    step("cs2", 1, 0, 0, 32'h0,  1, 32'h0000_0080, 1);
    step("cs3", 0, 0, 0, 32'h0,  1, 32'h0000_0084, 0);

    // Reset in the middle of an outstanding request
    IMemAck   = 1'b1;
    IMemRData = 32'hCAFE_F00D;
    rst_n     = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart at RESET_PC; redirect to top of address space and wrap
    step("wr0", 1, 0, 1, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1);
    step("wr1", 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1);
    step("wr2", 1, 0, 0, 32'h0,         1, 32'h0000_0000, 1);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
